// File: rtl/bin_mult_sched_if.sv
// Handshake bundle between the Wishbone-side producer/consumer, the job
// sequencer and the XNOR-popcount datapath.
interface bin_mult_sched_if;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_high;
  logic [31:0] in_low;
  logic [6:0]  thresh;
  logic        dp_start;
  logic [31:0] dp_high;
  logic [31:0] dp_low;
  logic [6:0]  dp_result;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        out_bit;
  logic        busy;
  logic [15:0] jobs_done;

  modport slave (
    input  clear, in_valid, in_high, in_low, thresh, dp_result, out_ready,
    output in_ready, dp_start, dp_high, dp_low, out_valid, out_count, out_bit,
           busy, jobs_done
  );

  modport master (
    output clear, in_valid, in_high, in_low, thresh, dp_result, out_ready,
    input  in_ready, dp_start, dp_high, dp_low, out_valid, out_count, out_bit,
           busy, jobs_done
  );
endinterface

// File: rtl/bin_mult_sched.sv
// Job sequencer for the XNOR-popcount datapath: operand FIFO, one-job-at-a-time
// launch/wait FSM and a one-entry result buffer with thresholded activation.
module bin_mult_sched #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input logic           clk,
  input logic           reset,
  bin_mult_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t state_reg, state_next;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic [31:0]   dp_high_reg, dp_low_reg;
  logic [6:0]    thresh_q;
  logic [6:0]    out_count_reg;
  logic          out_bit_reg;
  logic          out_valid_reg;
  logic [15:0]   jobs_done_reg;

  logic full, empty, push, pop, capture, launch, slot_free;

  assign full      = (count_reg == CNT_FULL);
  assign empty     = (count_reg == '0);
  assign push      = bus.in_valid && !full && !bus.clear;
  assign slot_free = !out_valid_reg || bus.out_ready;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        launch     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt_reg == '0) begin
          if (slot_free) begin
            capture    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A flush abandons the in-flight job before it can launch or capture.
    if (bus.clear) begin
      state_next = IDLE;
      pop        = 1'b0;
      capture    = 1'b0;
      launch     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        wait_cnt_reg <= WAIT_LOAD;
      end else if (state_reg == WAIT && wait_cnt_reg != '0) begin
        wait_cnt_reg <= wait_cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {bus.in_high, bus.in_low};
  end

  // Operands stay on dp_high/dp_low until the next pop, so the datapath sees stable inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_high_reg <= '0;
      dp_low_reg  <= '0;
      thresh_q    <= '0;
    end else if (pop) begin
      {dp_high_reg, dp_low_reg} <= mem[rd_ptr_reg];
      thresh_q                  <= bus.thresh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_count_reg <= '0;
      out_bit_reg   <= 1'b0;
      jobs_done_reg <= '0;
    end else if (bus.clear) begin
      out_valid_reg <= 1'b0;
    end else if (capture) begin
      out_valid_reg <= 1'b1;
      out_count_reg <= bus.dp_result;
      out_bit_reg   <= (bus.dp_result >= thresh_q);
      jobs_done_reg <= jobs_done_reg + 16'd1;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.dp_start  = launch;
  assign bus.dp_high   = dp_high_reg;
  assign bus.dp_low    = dp_low_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_bit   = out_bit_reg;
  assign bus.busy      = (state_reg != IDLE) || !empty;
  assign bus.jobs_done = jobs_done_reg;
endmodule

// File: tb/tb_bin_mult_sched.sv
// Self-checking bench for bin_mult_sched: scoreboard of expected results plus
// a behavioural XNOR-popcount datapath with fixed latency.
module tb_bin_mult_sched;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_mult_sched_if bus();

  bin_mult_sched #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         exp_jobs = 0;
  logic [6:0] exp_thresh = 7'd32;
  logic [7:0] sb_q[$];
  int         start_q[$];
  int         out_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] popc(input logic [31:0] h, input logic [31:0] l);
    return 7'($countones({h, l}));
  endfunction

  always @(posedge clk) cyc++;

  // Datapath model: result invalid (0x55) until LAT cycles after dp_start.
  logic [6:0] dp_pend;
  int         dp_lat = 0;
  initial bus.dp_result = '0;
  always @(posedge clk) begin
    if (bus.dp_start) begin
      dp_pend       <= popc(bus.dp_high, bus.dp_low);
      dp_lat        <= LAT - 1;
      bus.dp_result <= 7'h55;
    end else if (dp_lat == 1) begin
      bus.dp_result <= dp_pend;
      dp_lat        <= 0;
    end else if (dp_lat > 1) begin
      dp_lat <= dp_lat - 1;
    end
  end

  // Monitor: one sample per cycle, mid-cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    logic [6:0] c;
    if (reset || bus.clear) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        $display("OUT cyc=%0d count=%0d bit=%0b jobs_done=%0d", cyc, bus.out_count,
                 bus.out_bit, bus.jobs_done);
        out_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_out", 32'(bus.out_count), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("out_count", 32'(bus.out_count), 32'(e[6:0]));
          check("out_bit", 32'(bus.out_bit), 32'(e[7]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        c = popc(bus.in_high, bus.in_low);
        sb_q.push_back({(c >= exp_thresh), c});
      end
    end
    if (!reset && bus.dp_start) start_q.push_back(cyc);
  end

  task automatic push_job(input logic [31:0] h, input logic [31:0] l, output int acc_cyc);
    bus.in_valid = 1'b1;
    bus.in_high  = h;
    bus.in_low   = l;
    acc_cyc      = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (acc_cyc < 0) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.busy && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (start_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_start_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_dp_start"},  32'(bus.dp_start),  32'd0);
    check({tag, "_dp_high"},   bus.dp_high,        32'd0);
    check({tag, "_dp_low"},    bus.dp_low,         32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    check({tag, "_out_bit"},   32'(bus.out_bit),   32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_jobs_done"}, 32'(bus.jobs_done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n_start;
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_high   = '0;
    bus.in_low    = '0;
    bus.thresh    = 7'd32;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1;

    // Single job: timing and 64-ones result.
    bus.out_ready = 1'b1;
    exp_thresh    = 7'd32;
    start_q.delete();
    out_q.delete();
    push_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    wait_drain("single");
    exp_jobs += 1;
    check("single_starts", 32'(start_q.size()), 32'd1);
    if (start_q.size() > 0) check("single_start_lat", 32'(start_q[0] - t), 32'd2);
    check("single_outs", 32'(out_q.size()), 32'd1);
    if (out_q.size() > 0) check("single_out_lat", 32'(out_q[0] - t), 32'd5);
    check("single_jobs_done", 32'(bus.jobs_done), 32'(exp_jobs));

    // Fill with the consumer stalled.
    bus.out_ready = 1'b0;
    start_q.delete();
    out_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) push_job($urandom, $urandom, t);
    @(negedge clk);
    check("fill_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    push_job(32'h0F0F_0F0F, 32'hFFFF_0000, t);
    repeat (20) @(negedge clk);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill_starts", 32'(start_q.size()), 32'd2);
    check("fill_out_valid", 32'(bus.out_valid), 32'd1);
    check("fill_busy", 32'(bus.busy), 32'd1);
    check("fill_jobs_held", 32'(bus.jobs_done), 32'(exp_jobs + 1));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("fill");
    exp_jobs += DEPTH + 2;
    check("fill_outs", 32'(out_q.size()), 32'(DEPTH + 2));
    check("fill_jobs_done", 32'(bus.jobs_done), 32'(exp_jobs));

    // Streaming with thresh 0: every bit set, one result every LAT+2 cycles.
    bus.thresh = 7'd0;
    exp_thresh = 7'd0;
    out_q.delete();
    for (int i = 0; i < 8; i++) push_job($urandom, $urandom, t);
    wait_drain("stream");
    exp_jobs += 8;
    check("stream_outs", 32'(out_q.size()), 32'd8);
    for (int i = 1; i < out_q.size(); i++)
      check("stream_spacing", 32'(out_q[i] - out_q[i-1]), 32'(LAT + 2));

    // Threshold boundary 31/32, then thresh changed after the second pop.
    bus.thresh = 7'd32;
    exp_thresh = 7'd32;
    start_q.delete();
    push_job(32'h7FFF_FFFF, 32'h0000_0000, t);
    push_job(32'hFFFF_FFFF, 32'h0000_0000, t);
    wait_starts(2, "thr");
    bus.thresh = 7'h7F;
    wait_drain("thr");
    exp_jobs += 2;
    check("thr_last_bit", 32'(bus.out_bit), 32'd1);
    check("thr_last_count", 32'(bus.out_count), 32'd32);
    bus.thresh = 7'd32;

    // Clear in the WAIT sample cycle with three jobs queued.
    start_q.delete();
    push_job(32'h0000_FFFF, 32'hFFFF_FFFF, t);
    push_job($urandom, $urandom, t);
    push_job($urandom, $urandom, t);
    push_job($urandom, $urandom, t);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr_in_ready", 32'(bus.in_ready), 32'd1);
    check("clr_jobs_done", 32'(bus.jobs_done), 32'(exp_jobs));
    check("clr_dp_high", bus.dp_high, 32'h0000_FFFF);
    check("clr_out_count", 32'(bus.out_count), 32'd32);
    repeat (10) @(negedge clk);
    check("clr_no_start", 32'(start_q.size()), 32'd1);
    check("clr_no_out", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // jobs_done wrap from a preloaded 0xFFFE.
    force dut.jobs_done_reg = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.jobs_done_reg;
    push_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    wait_drain("wrap1");
    check("wrap_ffff", 32'(bus.jobs_done), 32'h0000_FFFF);
    push_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    wait_drain("wrap2");
    check("wrap_zero", 32'(bus.jobs_done), 32'd0);

    // Reset mid-WAIT discards the in-flight job.
    start_q.delete();
    push_job(32'hA5A5_A5A5, 32'h1234_5678, t);
    wait_starts(1, "rstmid");
    n_start = start_q.size();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rstmid");
    repeat (10) @(negedge clk);
    check("rstmid_no_out", 32'(bus.out_valid), 32'd0);
    check("rstmid_no_start", 32'(start_q.size()), 32'(n_start));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
